// File: rtl/gray_pkg.sv
// gray_pkg: shared width default and binary/Gray conversion helpers for the Gray datapath.
package gray_pkg;
  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH = 16;
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Prefix XOR from the MSB down; zero-extended narrower words convert unchanged.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_src_if.sv
// gray_counter_src_if: valid/ready Gray word stream with binary count and wrap sideband.
interface gray_counter_src_if #(parameter int WIDTH = 4);
  logic             gray_valid;
  logic             gray_ready;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             wrap;
  modport master (output gray_valid, gray_out, bin_out, wrap, input gray_ready);
  modport slave (input gray_valid, gray_out, bin_out, wrap, output gray_ready);
endinterface

// File: rtl/bin_to_gray.sv
// bin_to_gray: combinational binary to reflected Gray conversion.
module bin_to_gray #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter_src.sv
// gray_counter_src: loadable up/down counter emitting registered Gray words on a valid/ready stream.
module gray_counter_src import gray_pkg::*; #(parameter int WIDTH = GRAY_WIDTH) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  gray_counter_src_if.master gif
);
  logic             adv;
  logic             wrap_next;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  always_comb begin
    adv       = en & ~load & (~gif.gray_valid | gif.gray_ready);
    step      = up_dn ? gif.bin_out + 1'b1 : gif.bin_out - 1'b1;
    next_bin  = load ? load_bin : step;
    wrap_next = ~load & (up_dn ? &gif.bin_out : ~|gif.bin_out);
  end
  // Gray is computed on the next-count path so the register holds it directly.
  bin_to_gray #(.WIDTH(WIDTH)) u_b2g (.bin(next_bin), .gray(next_gray));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gif.bin_out    <= '0;
      gif.gray_out   <= '0;
      gif.gray_valid <= 1'b0;
      gif.wrap       <= 1'b0;
    end else if (load | adv) begin
      gif.bin_out    <= next_bin;
      gif.gray_out   <= next_gray;
      gif.gray_valid <= 1'b1;
      gif.wrap       <= wrap_next;
    end else if (gif.gray_ready) begin
      gif.gray_valid <= 1'b0;
    end
  end
endmodule

// File: doc/gray_counter_src.md
Name: gray_counter_src

Overview:
Upstream producer of Gray-coded words for the gray_to_binary stage. It holds a binary up/down count and emits each new count as a registered Gray word on a valid/ready handshake. The binary count can be loaded synchronously. Every emitted word is guaranteed single-bit-change from the previous word unless a load intervened, so the block also serves as the stimulus and pointer source for the Gray datapath.

Parameters:
WIDTH, 4, bit width of the count and of the Gray word (legal range 2..16)

Ports:
clk  input  1  single clock; all flops rise-edge triggered
rst_n  input  1  asynchronous, active-low reset
en  input  1  request to advance the count by one
up_dn  input  1  1 = count up, 0 = count down; sampled on the advancing edge
load  input  1  synchronous load of load_bin; has priority over en
load_bin  input  WIDTH  binary value to load
gray_ready  input  1  downstream accepts gray_out this cycle
gray_valid  output  1  gray_out holds an unconsumed word
gray_out  output  WIDTH  registered Gray code of bin_out
bin_out  output  WIDTH  registered binary count
wrap  output  1  sideband bit held with gray_out; 1 when that word resulted from a wrap

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without waiting for clk):
  - bin_out = 0, gray_out = 0, gray_valid = 0, wrap = 0.
  - Release is synchronous to clk.
- Word consumed: when gray_valid & gray_ready.
- Advance condition: adv = en & ~load & (~gray_valid | gray_ready). Advancing is therefore stalled only while a held word is not being consumed.
- On load (priority over adv, ignores backpressure):
  - bin_out <= load_bin.
  - gray_out <= load_bin ^ (load_bin >> 1).
  - gray_valid <= 1, wrap <= 0.
  - An unconsumed held word is overwritten.
- On adv:
  - next = bin_out + 1 if up_dn, else bin_out - 1, modulo 2^WIDTH.
  - bin_out <= next, gray_out <= next ^ (next >> 1), gray_valid <= 1.
  - wrap <= 1 if (up_dn and bin_out == all-ones) or (~up_dn and bin_out == 0); otherwise wrap <= 0.
- Otherwise: if gray_ready, then gray_valid <= 0. gray_out, bin_out and wrap keep their values.
- Latency: a new word appears on gray_out one cycle after the accepting edge. Sustained throughput is 1 word per cycle with gray_ready = 1.
- Backpressure:
  - While gray_valid = 1 and gray_ready = 0, all outputs hold and en is ignored.
  - en is a level request. An ignored en is not queued.
- The count 0 present at reset is never emitted, because gray_valid = 0. The first advance emits bin 1 (up) or all-ones (down).
- Invariants:
  - gray_out == bin_out ^ (bin_out >> 1) at all times.
  - Consecutive emitted words with no load between them differ in exactly 1 bit, including across a wrap.
- up_dn may change on any cycle. Only its value on the advancing edge matters.
- Simultaneous load & en: load wins and no increment is applied.

Decomposition:
- Shared package gray_pkg holds:
  - the WIDTH default constant;
  - function bin2gray(b) = b ^ (b >> 1);
  - function gray2bin, for the bench and for gray_to_binary.
- Natural sub-module: bin_to_gray, purely combinational, instantiated on the next-count path so that the output register captures the Gray word directly.

Test Plan (WIDTH = 4):
1. Reset, then en = 1, up_dn = 1, gray_ready = 1 for 5 cycles -> gray_out 0001, 0011, 0010, 0110, 0111; bin_out 1..5; wrap = 0; gray_valid = 1 from the first cycle after the first advance.
2. Up-wrap: load = 1, load_bin = 1110 -> gray 1001. Advance -> gray 1000 (bin 1111), wrap = 0. Advance -> gray 0000, wrap = 1. Advance -> gray 0001, wrap = 0.
3. Down-wrap: load 0000 -> gray 0000, valid = 1. up_dn = 0 and advance -> gray 1000, bin 1111, wrap = 1. Advance -> gray 1001, bin 1110.
4. Backpressure: with valid = 1 and gray 0011, gray_ready = 0 and en = 1 for 3 cycles -> gray 0011 held. Then gray_ready = 1 -> next word 0010. No word skipped.
5. Load while stalled: valid = 1, ready = 0, load_bin = 1010 -> gray 1111 and bin 1010 next cycle, valid = 1. Simultaneous load & en -> loaded value only.
6. Asynchronous reset mid-count: rst_n falls between clock edges at bin 0111 -> all outputs 0 before the next edge. After release, en -> gray 0001.
7. Scoreboard across all scenarios: feed each accepted gray_out through gray2bin and compare with bin_out. Check the single-bit-change invariant between consecutive non-load words.
